// File: rtl/pio_input_capture.sv
// pio_input_capture: Avalon-MM slave input port for push-buttons and switches.
// Each input bit is synchronized, debounced and edge-detected. Selected edges are
// latched in a write-1-to-clear capture register that drives a maskable level irq.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address[1:0]          word select: 0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAPTURE
//   chipselect, write_n   slave select and active-low write strobe
//   writedata[31:0]       write data
//   in_port[WIDTH-1:0]    raw asynchronous inputs
//   readdata[31:0]        combinational read data
//   irq                   level interrupt, |(edge_capture & irq_mask)
//   debounced[WIDTH-1:0]  debounced input state
module pio_input_capture #(
   parameter int unsigned      WIDTH           = 4,
   parameter int unsigned      DEBOUNCE_CYCLES = 50000,
   parameter int unsigned      EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq,
   output logic [WIDTH-1:0] debounced
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]            sync1_q, sync1_d;
   logic [WIDTH-1:0]            sync2_q, sync2_d;
   logic [WIDTH-1:0]            db_q, db_d;
   logic [WIDTH-1:0]            db_prev_q, db_prev_d;
   logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]            irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0]            edge_cap_q, edge_cap_d;

   logic                        wr_c;
   logic [WIDTH-1:0]            clr_c;
   logic [WIDTH-1:0]            edge_hit_c;
   logic                        unused_wdata_c;

   // Upper writedata bits have no destination when WIDTH < 32.
   assign unused_wdata_c = ^writedata;

   // Next-state: synchronizer, per-bit debounce, edge detect, register writes.
   always_comb begin
      sync1_d    = in_port;
      sync2_d    = sync1_q;
      db_d       = db_q;
      cnt_d      = cnt_q;
      db_prev_d  = db_q;
      irq_mask_d = irq_mask_q;
      edge_hit_c = '0;
      clr_c      = '0;
      wr_c       = chipselect & ~write_n;

      // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples;
      // any agreement restarts the count.
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (sync2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            db_d[i]  = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end

      if (EDGE_TYPE == 0) begin
         edge_hit_c = db_q & ~db_prev_q;
      end else if (EDGE_TYPE == 1) begin
         edge_hit_c = ~db_q & db_prev_q;
      end else begin
         edge_hit_c = db_q ^ db_prev_q;
      end

      if (wr_c && (address == 2'd2)) begin
         irq_mask_d = writedata[WIDTH-1:0];
      end
      if (wr_c && (address == 2'd3)) begin
         clr_c = writedata[WIDTH-1:0];
      end

      // A new edge in the same cycle as a clear keeps the bit set.
      edge_cap_d = (edge_cap_q & ~clr_c) | edge_hit_c;
   end

   // State registers; reset levels match the idle input so no false edge appears.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= IDLE_LEVEL;
         sync2_q    <= IDLE_LEVEL;
         db_q       <= IDLE_LEVEL;
         db_prev_q  <= IDLE_LEVEL;
         cnt_q      <= '0;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         db_q       <= db_d;
         db_prev_q  <= db_prev_d;
         cnt_q      <= cnt_d;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
      end
   end

   // Zero-wait-state read mux; reads have no side effects.
   always_comb begin
      readdata = '0;
      case (address)
         2'd0:    readdata = 32'(db_q);
         2'd2:    readdata = 32'(irq_mask_q);
         2'd3:    readdata = 32'(edge_cap_q);
         default: readdata = '0;
      endcase
   end

   assign irq       = |(edge_cap_q & irq_mask_q);
   assign debounced = db_q;

endmodule

// File: tb/tb_pio_input_capture.sv
// Bench for pio_input_capture: two instances (falling-edge and any-edge capture)
// share one bus and input stimulus and are compared every cycle against a
// sample-window reference model, plus literal checks at the scripted points.
module tb_pio_input_capture;

   localparam int W = 4;
   localparam int D = 4;
   localparam logic [W-1:0] IDLE = 4'hF;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [W-1:0]  in_port;
   logic [31:0]   readdata_f, readdata_a;
   logic          irq_f, irq_a;
   logic [W-1:0]  debounced_f, debounced_a;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pio_input_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1), .IDLE_LEVEL(IDLE)) u_fall (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata_f), .irq(irq_f), .debounced(debounced_f));

   pio_input_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .IDLE_LEVEL(IDLE)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata_a), .irq(irq_a), .debounced(debounced_a));

   // Reference model: a bit flips once the last D synchronized samples all
   // disagree with it; capture index 0 = falling edges, 1 = any edge.
   logic [W-1:0] m_s1, m_s2, m_db, m_dbp, m_mask;
   logic [W-1:0] m_win [D];
   logic [W-1:0] m_ec  [2];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = IDLE; m_s2 = IDLE; m_db = IDLE; m_dbp = IDLE; m_mask = '0;
      m_ec[0] = '0; m_ec[1] = '0;
      for (int j = 0; j < D; j++) m_win[j] = IDLE;
   endtask

   // Advance the model by one clock using the inputs present before the edge.
   task automatic model_clock();
      logic [W-1:0] db_new, clr, hit;
      logic         wr, all_diff;
      if (!reset_n) begin
         model_reset();
         return;
      end
      for (int j = D - 1; j > 0; j--) m_win[j] = m_win[j-1];
      m_win[0] = m_s2;
      db_new = m_db;
      for (int i = 0; i < W; i++) begin
         all_diff = 1'b1;
         for (int j = 0; j < D; j++) if (m_win[j][i] == m_db[i]) all_diff = 1'b0;
         if (all_diff) db_new[i] = ~m_db[i];
      end
      wr  = chipselect && !write_n;
      clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int k = 0; k < 2; k++) begin
         hit = (k == 0) ? (~m_db & m_dbp) : (m_db ^ m_dbp);
         m_ec[k] = (m_ec[k] & ~clr) | hit;
      end
      if (wr && address == 2'd2) m_mask = writedata[W-1:0];
      m_dbp = m_db;
      m_db  = db_new;
      m_s2  = m_s1;
      m_s1  = in_port;
   endtask

   function automatic logic [31:0] exp_rd(input int k, input logic [1:0] a);
      case (a)
         2'd0:    return 32'(m_db);
         2'd2:    return 32'(m_mask);
         2'd3:    return 32'(m_ec[k]);
         default: return 32'h0;
      endcase
   endfunction

   task automatic check_all();
      chk("db_fall", 32'(debounced_f), 32'(m_db));
      chk("db_any", 32'(debounced_a), 32'(m_db));
      chk("irq_fall", 32'(irq_f), 32'(|(m_ec[0] & m_mask)));
      chk("irq_any", 32'(irq_a), 32'(|(m_ec[1] & m_mask)));
      chk("rd_fall", readdata_f, exp_rd(0, address));
      chk("rd_any", readdata_a, exp_rd(1, address));
   endtask

   task automatic step();
      model_clock();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      step();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      address = a;
      #1;
      chk(tag, readdata_f, exp);
   endtask

   initial begin
      int hold [W];
      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = IDLE;
      model_reset();
      repeat (3) step();
      reset_n = 1'b1;

      // Reset state and idle inputs
      rd_chk("rst_data", 2'd0, 32'hF);
      rd_chk("rst_mask", 2'd2, 32'h0);
      rd_chk("rst_ec", 2'd3, 32'h0);
      chk("rst_irq", 32'(irq_f), 32'h0);
      for (int s = 0; s < 20; s++) begin
         step();
         chk("idle_ec", readdata_f, 32'h0);
      end

      // Clean press on bit 0
      in_port = 4'hE;
      for (int s = 0; s < 7; s++) begin
         step();
         if (s == 4) chk("press_db_early", 32'(debounced_f), 32'hF);
         if (s == 5) chk("press_db", 32'(debounced_f), 32'hE);
         if (s == 5) chk("press_ec_early", readdata_f, 32'h0);
         if (s == 6) chk("press_ec", readdata_f, 32'h1);
         if (s == 6) chk("press_irq_masked", 32'(irq_f), 32'h0);
      end
      bus_wr(2'd2, 32'h1);
      chk("mask_irq", 32'(irq_f), 32'h1);

      // Bounce rejection: 3-cycle pulse on bit 1
      address = 2'd3;
      in_port = 4'hC;
      repeat (3) step();
      in_port = 4'hE;
      repeat (8) step();
      chk("bounce_db", 32'(debounced_f), 32'hE);
      chk("bounce_ec", readdata_f, 32'h1);
      chk("bounce_cnt", 32'(u_fall.cnt_q[1]), 32'h0);

      // 4-cycle pulse is accepted
      in_port = 4'hC;
      repeat (4) step();
      in_port = 4'hE;
      repeat (12) step();
      chk("pulse4_ec", readdata_f, 32'h3);

      // W1C and set-wins collision
      bus_wr(2'd3, 32'h1);
      rd_chk("w1c", 2'd3, 32'h2);
      in_port = 4'hC;
      repeat (6) step();
      bus_wr(2'd3, 32'h2);
      rd_chk("collision", 2'd3, 32'h2);

      // Release: rising edges ignored by falling capture, taken by any-edge
      in_port = 4'hF;
      repeat (8) step();
      chk("release_db", 32'(debounced_f), 32'hF);
      chk("release_ec_fall", readdata_f, 32'h2);
      chk("release_ec_any", readdata_a, 32'h3);

      // Reset mid-debounce
      in_port = 4'hE;
      repeat (4) step();
      chk("cnt_before_rst", 32'(u_fall.cnt_q[0]), 32'h2);
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_cnt", 32'(u_fall.cnt_q[0]), 32'h0);
      chk("rst_db", 32'(debounced_f), 32'hF);
      chk("rst_irq_mid", 32'(irq_f), 32'h0);
      chk("rst_ec_mid", readdata_f, 32'h0);
      repeat (2) step();
      reset_n = 1'b1;
      for (int s = 0; s < 7; s++) begin
         step();
         if (s == 5) chk("post_rst_ec_early", readdata_f, 32'h0);
         if (s == 6) chk("post_rst_ec", readdata_f, 32'h1);
      end

      // Randomized traffic against the model
      for (int i = 0; i < W; i++) hold[i] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < W; i++) begin
            if (hold[i] == 0) begin
               in_port[i] = 1'($urandom_range(0, 1));
               hold[i] = int'($urandom_range(1, 8));
            end else begin
               hold[i]--;
            end
         end
         address = 2'($urandom_range(0, 3));
         writedata = $urandom;
         if ($urandom_range(0, 9) < 3) begin
            chipselect = 1'b1; write_n = 1'b0;
         end else begin
            chipselect = 1'($urandom_range(0, 1));
            write_n = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pio_input_capture.md
# pio_input_capture

Avalon-MM slave input port: the read-side counterpart of the core's LED output PIOs, for push-buttons and slide switches. It synchronizes and debounces each input bit and latches selected edges in a write-1-to-clear capture register. It raises a maskable level interrupt to the Nios II core. It sits on the core's data-master interconnect, next to the output PIO slaves.

## Interface
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a debounced bit changes (>=1). 50000 is 1 ms at 50 MHz.
- EDGE_TYPE, 1: edge that sets capture bits. 0 = rising, 1 = falling, 2 = any.
- IDLE_LEVEL, {WIDTH{1'b1}}: reset value of the synchronizer, debounced and delayed registers. It matches the inactive input level, so reset does not create a false edge.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous inputs.
- readdata  out  32  read data, combinational.
- irq  out  1  level interrupt, active-high.
- debounced  out  WIDTH  debounced input state, for direct fabric use.

## Operation
- Register map (word addresses):
  - 0 DATA: read-only, debounced state.
  - 1: reserved, reads 0.
  - 2 IRQ_MASK: read/write, bits [WIDTH-1:0].
  - 3 EDGE_CAPTURE: read; write-1-to-clear.
- Writes to addresses 0 and 1 are ignored.
- Unused upper readdata bits read 0.
- Write strobe is chipselect && !write_n.
- readdata is a combinational mux of address; reads have no side effects.
- Synchronizer: two flops per bit, sync1 <= in_port, sync2 <= sync1.
- Debounce, per bit i, using counter cnt[i] of width $clog2(DEBOUNCE_CYCLES+1):
  - If sync2[i] == db[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: db[i] <= sync2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any return to agreement restarts the count. Glitches shorter than DEBOUNCE_CYCLES are rejected.
- Edge detect: db_d <= db. Edge conditions, per bit:
  - rise = db & ~db_d
  - fall = ~db & db_d
  - any = db ^ db_d
- EDGE_CAPTURE: bit i sets when the selected edge condition is true on bit i. It clears when EDGE_CAPTURE is written with writedata[i] = 1.
  - Set and clear in the same cycle: set wins.
  - Bits written with 0 are unchanged.
- irq = |(edge_capture & irq_mask), combinational from registers. It stays high until the bit is cleared or masked.
- debounced = db.
- Reset values:
  - sync1, sync2, db, db_d = IDLE_LEVEL.
  - cnt, irq_mask, edge_capture = 0.
  - irq = 0.
  - readdata = 0 for address 1. For other addresses it reflects the reset register values.
- Reset asserted mid-count or mid-edge: all state returns to reset values immediately. No edge is captured from the reset transition.

## Timing
- For an in_port change first sampled at edge k, with no bounce:
  - sync2 changes at edge k+1.
  - db changes at edge k+DEBOUNCE_CYCLES+1.
  - edge_capture bit and irq assert at edge k+DEBOUNCE_CYCLES+2.
- Mask write at edge m: irq reflects the new mask after edge m (same cycle as register update).
- Clear write at edge m: edge_capture bit reads 0 and irq deasserts after edge m, unless a new edge sets it at edge m.
- Read: readdata valid in the same cycle as address; zero wait states.
- Bits are independent: a simultaneous edge on several bits sets all of them in one cycle.

## Test plan
- Bench configuration: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, IDLE_LEVEL=4'hF.
- Reset: hold in_port=4'hF and release reset_n.
  - Required: DATA reads 0xF, EDGE_CAPTURE reads 0, IRQ_MASK reads 0, irq=0.
  - No capture over 20 cycles.
- Clean press: drive in_port[0]=0 before edge 0.
  - Required: debounced=4'hE at edge 5, EDGE_CAPTURE=0x1 at edge 6, irq stays 0 (mask 0).
  - Write IRQ_MASK=0x1: irq=1 the next cycle.
- Bounce rejection: pulse in_port[1] low for 3 cycles, then high.
  - Required: debounced unchanged, EDGE_CAPTURE unchanged, cnt[1] back to 0.
  - A 4-cycle pulse does change db[1] (low) and sets EDGE_CAPTURE bit 1.
- W1C and collision: with EDGE_CAPTURE=0x3, write 0x1.
  - Required: reads 0x2.
  - Write 0x2 in the same cycle a new falling edge on bit 1 is detected: bit 1 stays 1.
- Release edge ignored: return in_port[0] to 1 with EDGE_TYPE=1.
  - Required: db[0]=1 after 5 cycles, no capture.
  - Rerun with EDGE_TYPE=2: bit 0 captured.
- Reset mid-debounce: assert reset_n=0 two cycles into a 4-cycle count.
  - Required: cnt=0, db=4'hF, edge_capture=0, irq=0 immediately.
  - Inputs still low after release: edge captured after 4+2 cycles.
